mips_multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM that sequences the shared MIPS datapath: one memory port, one ALU, one register file, reused across FETCH/DECODE/EXEC/MEM/WB steps.
- Replaces per-instruction combinational decode with per-state control words.
- Stalls on a memory ready handshake and counts retired instructions.
- Sits between the instruction register's opcode field and the datapath muxes and enables.

---
 rtl/mips_pkg.sv | 60 ++++++
 rtl/mips_multicycle_ctrl_if.sv | 37 +++
 rtl/mips_ctrl_decode.sv | 76 +++++++
 rtl/mips_multicycle_ctrl.sv | 90 +++++++++
 tb/tb_mips_multicycle_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, datapath
// select codes, FSM state encodings and the per-state control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_SW       = 6'b101011;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_ADDI     = 6'b001000;
    localparam logic [5:0] OP_J        = 6'b000010;

    localparam logic [2:0] ALU_OP_ADD   = 3'b000;
    localparam logic [2:0] ALU_OP_SUB   = 3'b001;
    localparam logic [2:0] ALU_OP_RTYPE = 3'b010;

    localparam logic [1:0] ALUSRCB_B       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // FETCH must stay 0 so the debug port reads FETCH while held in reset.
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_ADDI_EXEC = 4'd8,
        S_ADDI_WB   = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    typedef struct packed {
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       pc_write_cond;
        logic       retire;
        logic       mem_wait;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: opcode/flags/memory handshake in, control word out.
interface mips_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic             zero;
    logic             mem_ready;
    logic             pc_en;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic [1:0]       pc_source;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;
    logic [3:0]       state_dbg;

    modport master (
        input  op, zero, mem_ready,
        output pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
               instr_count, state_dbg
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
               instr_count, state_dbg
    );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Purely combinational state -> control word decode; handshake gating is
// applied by the FSM using the mem_wait flag.
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALUSRCB_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.mem_wait  = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_b = ALUSRCB_IMM_SH2;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_wait = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_wait  = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_B;
                ctrl.alu_op    = ALU_OP_RTYPE;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALUSRCB_B;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.retire        = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.retire    = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: state register, opcode-driven sequencing,
// memory-ready stalls and a retired-instruction counter.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    mips_multicycle_ctrl_if.master  bus
);
    state_t           state;
    state_t           state_next;
    ctrl_t            ctrl;
    logic             advance;
    logic             illegal;
    logic             pc_write;
    logic [CNT_W-1:0] count;

    mips_ctrl_decode u_decode (
        .state (state),
        .ctrl  (ctrl)
    );

    // Memory-bound states only make progress (and commit) once mem_ready is seen.
    assign advance  = !ctrl.mem_wait || bus.mem_ready;
    assign pc_write = ctrl.pc_write && advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        illegal    = 1'b0;
        case (state)
            S_FETCH:     state_next = advance ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_RTYPE, OP_SPECIAL2: state_next = S_R_EXEC;
                    OP_LW, OP_SW:          state_next = S_MEM_ADDR;
                    OP_BEQ:                state_next = S_BRANCH;
                    OP_ADDI:               state_next = S_ADDI_EXEC;
                    OP_J:                  state_next = S_JUMP;
                    default: begin
                        state_next = S_FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR:  state_next = (bus.op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:    state_next = advance ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:    state_next = advance ? S_FETCH : S_MEM_WR;
            S_R_EXEC:    state_next = S_R_WB;
            S_ADDI_EXEC: state_next = S_ADDI_WB;
            default:     state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (ctrl.retire && advance) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Every output is forced low while reset is held, including FETCH's read request.
    assign bus.pc_en       = rst_n && (pc_write || (ctrl.pc_write_cond && bus.zero));
    assign bus.i_or_d      = rst_n && ctrl.i_or_d;
    assign bus.mem_read    = rst_n && ctrl.mem_read;
    assign bus.mem_write   = rst_n && ctrl.mem_write;
    assign bus.ir_write    = rst_n && ctrl.ir_write && advance;
    assign bus.reg_dst     = rst_n && ctrl.reg_dst;
    assign bus.mem_to_reg  = rst_n && ctrl.mem_to_reg;
    assign bus.reg_write   = rst_n && ctrl.reg_write;
    assign bus.alu_src_a   = rst_n && ctrl.alu_src_a;
    assign bus.alu_src_b   = rst_n ? ctrl.alu_src_b : 2'b00;
    assign bus.alu_op      = rst_n ? ctrl.alu_op : 3'b000;
    assign bus.pc_source   = rst_n ? ctrl.pc_source : 2'b00;
    assign bus.illegal_op  = rst_n && illegal;
    assign bus.instr_count = count;
    assign bus.state_dbg   = rst_n ? state : S_FETCH;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed scenarios plus a randomized
// instruction stream checked against a phase-level reference model.
module tb_mips_multicycle_ctrl;
    import mips_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] exp_count;
    logic [16:0]      outs;

    mips_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign outs = {bus.pc_en, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                   bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                   bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_op};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.op        = OP_LW;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (outs !== 17'h0) begin errors++; $display("FAIL reset_outs: got %h expected 0", outs); end
        checks++; if (bus.state_dbg !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state_dbg); end
        checks++; if (bus.instr_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.instr_count); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL release_mem_read: got %b expected 1", bus.mem_read); end
        // Walk an lw into MEM_RD, stall it, then pull reset mid-instruction.
        tick(); tick(); tick();
        bus.mem_ready = 1'b0;
        #1;
        checks++; if (bus.state_dbg !== 4'd3 || bus.mem_read !== 1'b1 || bus.i_or_d !== 1'b1) begin
            errors++; $display("FAIL memrd_entry: got state %0d rd %b iord %b expected 3 1 1", bus.state_dbg, bus.mem_read, bus.i_or_d);
        end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.state_dbg !== 4'd0) begin errors++; $display("FAIL midreset_state: got %0d expected 0", bus.state_dbg); end
        checks++; if (outs !== 17'h0) begin errors++; $display("FAIL midreset_outs: got %h expected 0", outs); end
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.mem_ready = 1'b1;
        exp_count     = '0;
        #1;
        checks++; if (bus.mem_read !== 1'b1 || bus.state_dbg !== 4'd0) begin
            errors++; $display("FAIL post_reset: got rd %b state %0d expected 1 0", bus.mem_read, bus.state_dbg);
        end
        checks++; if (bus.instr_count !== exp_count) begin errors++; $display("FAIL post_reset_count: got %0d expected %0d", bus.instr_count, exp_count); end
    endtask

    task automatic test_lw();
        logic [3:0] seq [5];
        seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        bus.op = OP_LW; bus.mem_ready = 1'b1; bus.zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (bus.state_dbg !== seq[i]) begin errors++; $display("FAIL lw_state c%0d: got %0d expected %0d", i, bus.state_dbg, seq[i]); end
            checks++; if ({bus.reg_write, bus.mem_to_reg} !== ((i == 4) ? 2'b11 : 2'b00)) begin
                errors++; $display("FAIL lw_wb c%0d: got %b%b expected %0d", i, bus.reg_write, bus.mem_to_reg, (i == 4) ? 11 : 0);
            end
            tick();
        end
        exp_count++;
        checks++; if (bus.instr_count !== exp_count || bus.state_dbg !== 4'd0) begin
            errors++; $display("FAIL lw_retire: got count %0d state %0d expected %0d 0", bus.instr_count, bus.state_dbg, exp_count);
        end
    endtask

    task automatic test_sw_wait();
        int wr_cycles;
        wr_cycles = 0;
        bus.op = OP_SW; bus.zero = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.mem_ready = !(i >= 3 && i <= 5);
            #1;
            if (bus.mem_write === 1'b1) wr_cycles++;
            checks++; if (bus.mem_write !== (i >= 3) || bus.i_or_d !== (i >= 3) || bus.mem_read !== (i == 0)) begin
                errors++; $display("FAIL sw_mem c%0d: got wr %b iord %b rd %b expected %b %b %b", i, bus.mem_write, bus.i_or_d, bus.mem_read, i >= 3, i >= 3, i == 0);
            end
            checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL sw_regwrite c%0d: got %b expected 0", i, bus.reg_write); end
            tick();
        end
        bus.mem_ready = 1'b1;
        exp_count++;
        checks++; if (wr_cycles != 4) begin errors++; $display("FAIL sw_wr_cycles: got %0d expected 4", wr_cycles); end
        checks++; if (bus.instr_count !== exp_count || bus.state_dbg !== 4'd0) begin
            errors++; $display("FAIL sw_retire: got count %0d state %0d expected %0d 0", bus.instr_count, bus.state_dbg, exp_count);
        end
    endtask

    task automatic test_beq();
        logic z;
        bus.op = OP_BEQ; bus.mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            z = (k == 0);
            bus.zero = z;
            for (int i = 0; i < 3; i++) begin
                #1;
                if (i == 2) begin
                    checks++; if (bus.state_dbg !== 4'd10 || bus.pc_en !== z || bus.pc_source !== 2'b01 || bus.alu_op !== 3'b001) begin
                        errors++; $display("FAIL beq_branch z%b: got state %0d pc_en %b src %b aluop %b expected 10 %b 01 001", z, bus.state_dbg, bus.pc_en, bus.pc_source, bus.alu_op, z);
                    end
                end else if (i == 1) begin
                    checks++; if (bus.pc_en !== 1'b0 || bus.alu_src_b !== 2'b11) begin
                        errors++; $display("FAIL beq_decode: got pc_en %b srcb %b expected 0 11", bus.pc_en, bus.alu_src_b);
                    end
                end
                tick();
            end
            exp_count++;
        end
        checks++; if (bus.instr_count !== exp_count) begin errors++; $display("FAIL beq_count: got %0d expected %0d", bus.instr_count, exp_count); end
    endtask

    task automatic test_illegal();
        int pulses;
        pulses = 0;
        bus.op = 6'b111111; bus.mem_ready = 1'b1; bus.zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.illegal_op === 1'b1) pulses++;
            if (i == 1) begin
                checks++; if (bus.illegal_op !== 1'b1 || bus.state_dbg !== 4'd1) begin
                    errors++; $display("FAIL illegal_decode: got ill %b state %0d expected 1 1", bus.illegal_op, bus.state_dbg);
                end
            end
            if (i == 2) begin
                checks++; if (bus.state_dbg !== 4'd0) begin errors++; $display("FAIL illegal_next: got %0d expected 0", bus.state_dbg); end
                bus.op = OP_RTYPE;
                #1;
            end
            if (i < 2) tick();
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL illegal_pulses: got %0d expected 1", pulses); end
        checks++; if (bus.instr_count !== exp_count) begin errors++; $display("FAIL illegal_count: got %0d expected %0d", bus.instr_count, exp_count); end
    endtask

    task automatic test_wrap();
        int n;
        bus.op = OP_RTYPE; bus.mem_ready = 1'b1; bus.zero = 1'b0;
        n = 15 - int'(exp_count);
        for (int k = 0; k < n; k++) begin
            repeat (4) tick();
            exp_count++;
        end
        #1;
        checks++; if (bus.instr_count !== 4'hF) begin errors++; $display("FAIL wrap_pre: got %0d expected 15", bus.instr_count); end
        for (int i = 0; i < 4; i++) begin
            #1;
            if (i == 2) begin
                checks++; if (bus.alu_op !== 3'b010 || bus.alu_src_a !== 1'b1 || bus.alu_src_b !== 2'b00) begin
                    errors++; $display("FAIL rexec: got aluop %b srca %b srcb %b expected 010 1 00", bus.alu_op, bus.alu_src_a, bus.alu_src_b);
                end
            end
            if (i == 3) begin
                checks++; if (bus.reg_dst !== 1'b1 || bus.reg_write !== 1'b1 || bus.mem_to_reg !== 1'b0) begin
                    errors++; $display("FAIL rwb: got dst %b wr %b m2r %b expected 1 1 0", bus.reg_dst, bus.reg_write, bus.mem_to_reg);
                end
            end
            tick();
        end
        exp_count++;
        checks++; if (bus.instr_count !== 4'h0) begin errors++; $display("FAIL wrap_post: got %0d expected 0", bus.instr_count); end
    endtask

    // Reference model: an instruction is a list of phases; phase 0 is the fetch,
    // memory phases only complete on mem_ready, every other phase takes one cycle.
    task automatic test_random();
        logic [5:0] legal [7];
        logic [5:0] op;
        logic       rdy, z;
        logic       is_lw, is_sw, is_r, is_addi, is_beq, is_j, is_ill;
        logic       mem_rd_e, mem_wr_e, regw_e, ill_e, pcen_e;
        int         len, idx, guard;
        legal = '{OP_RTYPE, OP_SPECIAL2, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 7) begin
                op = 6'b000000;
                while (op == 6'b000000 || op == 6'b011100 || op == 6'b100011 || op == 6'b101011 ||
                       op == 6'b000100 || op == 6'b001000 || op == 6'b000010)
                    op = 6'($urandom_range(0, 63));
            end else begin
                op = legal[$urandom_range(0, 6)];
            end
            is_lw   = (op == 6'b100011);
            is_sw   = (op == 6'b101011);
            is_r    = (op == 6'b000000) || (op == 6'b011100);
            is_addi = (op == 6'b001000);
            is_beq  = (op == 6'b000100);
            is_j    = (op == 6'b000010);
            is_ill  = !(is_lw || is_sw || is_r || is_addi || is_beq || is_j);
            len     = is_lw ? 5 : (is_sw || is_r || is_addi) ? 4 : (is_beq || is_j) ? 3 : 2;
            idx     = 0;
            guard   = 0;
            bus.op  = op;
            while (idx < len && guard < 200) begin
                rdy           = ($urandom_range(0, 3) != 0);
                z             = 1'($urandom_range(0, 1));
                bus.mem_ready = rdy;
                bus.zero      = z;
                #1;
                mem_rd_e = (idx == 0) || (is_lw && idx == 3);
                mem_wr_e = is_sw && idx == 3;
                regw_e   = (is_lw && idx == 4) || ((is_r || is_addi) && idx == 3);
                ill_e    = is_ill && idx == 1;
                pcen_e   = (idx == 0 && rdy) || (is_beq && idx == 2 && z) || (is_j && idx == 2);
                checks++;
                if ({bus.mem_read, bus.mem_write, bus.reg_write, bus.illegal_op, bus.pc_en, bus.ir_write} !==
                    {mem_rd_e, mem_wr_e, regw_e, ill_e, pcen_e, (idx == 0 && rdy)}) begin
                    errors++;
                    $display("FAIL rand op=%b phase %0d: got rd/wr/rw/ill/pcen/irw %b%b%b%b%b%b expected %b%b%b%b%b%b",
                             op, idx, bus.mem_read, bus.mem_write, bus.reg_write, bus.illegal_op, bus.pc_en, bus.ir_write,
                             mem_rd_e, mem_wr_e, regw_e, ill_e, pcen_e, (idx == 0 && rdy));
                end
                tick();
                if (!((mem_rd_e || mem_wr_e) && !rdy)) idx++;
                guard++;
            end
            if (!is_ill) exp_count++;
            checks++;
            if (bus.instr_count !== exp_count || bus.state_dbg !== 4'd0) begin
                errors++;
                $display("FAIL rand_retire op=%b: got count %0d state %0d expected %0d 0", op, bus.instr_count, bus.state_dbg, exp_count);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq();
        test_illegal();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
